// File: rtl/buffer_unpacker.sv
// buffer_unpacker: fetches PAR_READ-word groups from the circular buffer
// and serializes them, one word per cycle, onto a valid/ready stream.
module buffer_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_READ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_data [0:PAR_READ-1],
  input  logic                  buf_empty,
  output logic                  buf_read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int IW = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
  localparam logic [IW-1:0] LAST = IW'(PAR_READ - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t                  state_q;
  logic [IW-1:0]           idx_q;
  logic [DATA_WIDTH-1:0]   hold_q [0:PAR_READ-1];
  logic                    is_last;
  logic                    last_xfer;

  assign is_last   = (idx_q == LAST);
  assign last_xfer = (state_q == DRAIN) && out_ready && is_last;

  // Refill on the final transfer so a ready consumer never sees a bubble.
  assign buf_read_enable = rst && !buf_empty &&
                           ((state_q == IDLE) || last_xfer);

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && is_last;

  if (PAR_READ == 1) begin : g_one
    assign out_data = hold_q[0];
  end else begin : g_many
    assign out_data = hold_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < PAR_READ; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (buf_read_enable) begin
            for (int i = 0; i < PAR_READ; i++) begin
              hold_q[i] <= buf_data[i];
            end
            idx_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (is_last) begin
              idx_q <= '0;
              if (buf_read_enable) begin
                for (int i = 0; i < PAR_READ; i++) begin
                  hold_q[i] <= buf_data[i];
                end
              end else begin
                state_q <= IDLE;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_unpacker.sv
// tb_buffer_unpacker: table vectors plus scoreboard for PAR_READ=4 and
// PAR_READ=1 instances fed from a modelled circular buffer.
module tb_buffer_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       e4, e1, rdy4, rdy1;
  logic [7:0] d4 [0:3];
  logic [7:0] d1 [0:0];
  logic       rd4, v4, ol4, b4;
  logic [7:0] od4;
  logic       rd1, v1, ol1, b1;
  logic [7:0] od1;

  buffer_unpacker #(.DATA_WIDTH(8), .PAR_READ(4)) u4 (
    .clk(clk), .rst(rst), .buf_data(d4), .buf_empty(e4),
    .buf_read_enable(rd4), .out_data(od4), .out_valid(v4),
    .out_ready(rdy4), .out_last(ol4), .busy(b4)
  );

  buffer_unpacker #(.DATA_WIDTH(8), .PAR_READ(1)) u1 (
    .clk(clk), .rst(rst), .buf_data(d1), .buf_empty(e1),
    .buf_read_enable(rd1), .out_data(od1), .out_valid(v1),
    .out_ready(rdy1), .out_last(ol1), .busy(b1)
  );

  typedef logic [3:0][7:0] grp_t;
  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;
  typedef struct {
    logic       rdy;
    logic       rd;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       b;
  } vec_t;

  grp_t       g4 [$];
  logic [7:0] g1 [$];
  exp_t       sb4 [$];
  exp_t       sb1 [$];

  int checks = 0;
  int failures = 0;
  int nrd4, nxf4, lastrd4, first_xf, last_xf, cyc;
  logic prev_rd4 = 1'b0;

  function automatic grp_t mk(logic [7:0] a, logic [7:0] b,
                              logic [7:0] c, logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step(input logic rs, input logic r4, input logic r1);
    exp_t x;
    @(negedge clk);
    rst  = rs;
    rdy4 = r4;
    rdy1 = r1;
    e4 = (g4.size() == 0);
    if (!e4) for (int i = 0; i < 4; i++) d4[i] = g4[0][i];
    e1 = (g1.size() == 0);
    if (!e1) d1[0] = g1[0];
    #1;
    if (rd4) begin
      chk("rd4_while_empty", {31'b0, e4}, 0);
      chk("rd4_back_to_back", {31'b0, prev_rd4}, 0);
      if (!e4) begin
        for (int i = 0; i < 4; i++) sb4.push_back('{d: g4[0][i], l: (i == 3)});
        void'(g4.pop_front());
      end
      nrd4++;
      if (v4 && ol4) lastrd4++;
    end
    prev_rd4 = rd4;
    if (v4 && rdy4) begin
      if (sb4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb4_unexpected: got %0h expected none", od4);
      end else begin
        x = sb4.pop_front();
        chk("sb4_data", {24'b0, od4}, {24'b0, x.d});
        chk("sb4_last", {31'b0, ol4}, {31'b0, x.l});
      end
      nxf4++;
      if (first_xf < 0) first_xf = cyc;
      last_xf = cyc;
    end
    if (rd1 && !e1) begin
      sb1.push_back('{d: g1[0], l: 1'b1});
      void'(g1.pop_front());
    end
    if (v1 && rdy1) begin
      if (sb1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb1_unexpected: got %0h expected none", od1);
      end else begin
        x = sb1.pop_front();
        chk("sb1_data", {24'b0, od1}, {24'b0, x.d});
        chk("sb1_last", {31'b0, ol1}, {31'b0, x.l});
      end
    end
    cyc++;
  endtask

  vec_t tv [6];

  initial begin
    tv[0] = '{rdy: 1, rd: 1, v: 0, d: 8'h00, l: 0, b: 0};
    tv[1] = '{rdy: 1, rd: 0, v: 1, d: 8'h11, l: 0, b: 1};
    tv[2] = '{rdy: 1, rd: 0, v: 1, d: 8'h22, l: 0, b: 1};
    tv[3] = '{rdy: 1, rd: 0, v: 1, d: 8'h33, l: 0, b: 1};
    tv[4] = '{rdy: 1, rd: 0, v: 1, d: 8'h44, l: 1, b: 1};
    tv[5] = '{rdy: 1, rd: 0, v: 0, d: 8'h00, l: 0, b: 0};

    rst = 1'b0; rdy4 = 1'b1; rdy1 = 1'b1; e4 = 1'b1; e1 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = '0;
    d1[0] = '0;
    cyc = 0; nrd4 = 0; nxf4 = 0; lastrd4 = 0; first_xf = -1; last_xf = -1;

    // reset held with data available
    g4.push_back(mk(8'h11, 8'h22, 8'h33, 8'h44));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("rst_rd", {31'b0, rd4}, 0);
      chk("rst_valid", {31'b0, v4}, 0);
      chk("rst_data", {24'b0, od4}, 0);
      chk("rst_busy", {31'b0, b4}, 0);
    end

    // single group, cycle-by-cycle vectors
    for (int k = 0; k < 6; k++) begin
      step(1'b1, tv[k].rdy, 1'b1);
      chk("tv_rd", {31'b0, rd4}, {31'b0, tv[k].rd});
      chk("tv_valid", {31'b0, v4}, {31'b0, tv[k].v});
      chk("tv_last", {31'b0, ol4}, {31'b0, tv[k].l});
      chk("tv_busy", {31'b0, b4}, {31'b0, tv[k].b});
      if (tv[k].v) chk("tv_data", {24'b0, od4}, {24'b0, tv[k].d});
    end

    // back-to-back groups
    for (int g = 1; g <= 3; g++) begin
      g4.push_back(mk(8'(g * 16 + 1), 8'(g * 16 + 2),
                      8'(g * 16 + 3), 8'(g * 16 + 4)));
    end
    nrd4 = 0; nxf4 = 0; lastrd4 = 0; first_xf = -1;
    for (int k = 0; k < 14; k++) step(1'b1, 1'b1, 1'b1);
    chk("b2b_reads", nrd4, 3);
    chk("b2b_words", nxf4, 12);
    chk("b2b_span", last_xf - first_xf, 11);
    chk("b2b_rd_on_last", lastrd4, 2);
    chk("b2b_idle", {31'b0, v4}, 0);

    // backpressure at idx 2 with next group waiting
    g4.push_back(mk(8'h11, 8'h22, 8'h33, 8'h44));
    g4.push_back(mk(8'h55, 8'h66, 8'h77, 8'h88));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("bp_data", {24'b0, od4}, 32'h33);
      chk("bp_valid", {31'b0, v4}, 1);
      chk("bp_rd", {31'b0, rd4}, 0);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("bp_resume", {24'b0, od4}, 32'h33);
    step(1'b1, 1'b1, 1'b1);
    chk("bp_refill", {31'b0, rd4}, 1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1);
    chk("bp_idle", {31'b0, v4}, 0);

    // reset in the middle of a group
    g4.push_back(mk(8'hA1, 8'hA2, 8'hA3, 8'hA4));
    g4.push_back(mk(8'hB1, 8'hB2, 8'hB3, 8'hB4));
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("mr_idx1", {24'b0, od4}, 32'hA2);
    step(1'b0, 1'b0, 1'b1);
    chk("mr_rd_in_rst", {31'b0, rd4}, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("mr_valid", {31'b0, v4}, 0);
    chk("mr_data", {24'b0, od4}, 0);
    chk("mr_busy", {31'b0, b4}, 0);
    chk("mr_rd", {31'b0, rd4}, 0);
    sb4.delete();
    step(1'b1, 1'b1, 1'b1);
    chk("mr_reread", {31'b0, rd4}, 1);
    step(1'b1, 1'b1, 1'b1);
    chk("mr_restart", {24'b0, od4}, 32'hB1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("mr_idle", {31'b0, v4}, 0);

    // PAR_READ = 1, two reads back to back
    g1.push_back(8'hA5);
    g1.push_back(8'hA5);
    step(1'b1, 1'b1, 1'b1);
    chk("p1_rd0", {31'b0, rd1}, 1);
    chk("p1_v0", {31'b0, v1}, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("p1_rd1", {31'b0, rd1}, 1);
    chk("p1_v1", {31'b0, v1}, 1);
    chk("p1_d1", {24'b0, od1}, 32'hA5);
    chk("p1_l1", {31'b0, ol1}, 1);
    step(1'b1, 1'b1, 1'b1);
    chk("p1_rd2", {31'b0, rd1}, 0);
    chk("p1_v2", {31'b0, v1}, 1);
    chk("p1_l2", {31'b0, ol1}, 1);
    step(1'b1, 1'b1, 1'b1);
    chk("p1_v3", {31'b0, v1}, 0);
    chk("p1_busy3", {31'b0, b1}, 0);

    chk("sb4_drained", sb4.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    chk("g4_consumed", g4.size(), 0);
    chk("g1_consumed", g1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
